// File: rtl/bist_pkg.sv
// Shared types and constant helpers for the BIST session controller: FSM states,
// maximal-length tap masks for the LFSRs and MISR, and the result-folding function.
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_CMP   = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Fibonacci shift-left taps; feedback into bit 0 is the XOR of the masked bits.
   function automatic logic [15:0] lfsr_taps(input int w);
      case (w)
         4:       return 16'h0009;
         5:       return 16'h0012;
         6:       return 16'h0021;
         7:       return 16'h0041;
         8:       return 16'h008E;
         9:       return 16'h0108;
         10:      return 16'h0204;
         11:      return 16'h0402;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0009;
      endcase
   endfunction

   function automatic logic [15:0] sig_taps(input int w);
      case (w)
         2:       return 16'h0003;
         3:       return 16'h0006;
         default: return lfsr_taps(w);
      endcase
   endfunction

   // Zero-extend the low in_w bits of data to a multiple of sig_w and XOR the chunks.
   function automatic logic [15:0] fold(input logic [63:0] data, input int in_w, input int sig_w);
      logic [15:0] acc;
      int          pos;
      acc = '0;
      pos = 0;
      for (int i = 0; i < 64; i++) begin
         if (i < in_w) begin
            acc[pos[3:0]] ^= data[i];
            pos = (pos == sig_w - 1) ? 0 : pos + 1;
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts in its own feedback and XORs in the
// folded DUT result each enabled cycle; synchronous clear has priority over enable.
module bist_misr
   import bist_pkg::*;
#(
   parameter int unsigned SIG_W = 4,
   parameter int unsigned IN_W  = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [IN_W-1:0]  data_i,
   output logic [SIG_W-1:0] sig_o
);

   localparam logic [SIG_W-1:0] TAP_SIG = SIG_W'(sig_taps(SIG_W));

   logic [SIG_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = '0;
      end else if (en_i) begin
         sig_d = {sig_q[SIG_W-2:0], ^(sig_q & TAP_SIG)} ^ SIG_W'(fold(64'(data_i), IN_W, SIG_W));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/bist_session_ctrl.sv
// Multi-session BIST controller: two LFSR pattern generators, MISR compaction and a
// golden-signature table with learn/check modes. Diagnostics exist only with BIST_DIAG_EN.
module bist_session_ctrl
   import bist_pkg::*;
#(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned SIG_W  = 4,
   parameter int unsigned N_PAT  = 16,
   parameter int unsigned N_SESS = 14,
   parameter int unsigned SEED_A = 1,
   parameter int unsigned SEED_B = 'h2A,
   localparam int unsigned SESS_W = $clog2(N_SESS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              learn,
   input  logic [WIDTH:0]    dut_sum,
   output logic [WIDTH-1:0]  tpg_a,
   output logic [WIDTH-1:0]  tpg_b,
   output logic              tpg_cin,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SESS_W-1:0] sess,
   output logic [SIG_W-1:0]  sig
`ifdef BIST_DIAG_EN
   ,
   output logic [SESS_W-1:0] fail_sess,
   output logic [SIG_W-1:0]  fail_sig,
   output logic              fail_any
`endif
);

   localparam int unsigned       CNT_W      = (N_PAT > 1) ? $clog2(N_PAT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(N_PAT - 1);
   localparam logic [SESS_W-1:0] SESS_LAST  = SESS_W'(N_SESS - 1);
   localparam logic [WIDTH-1:0]  TAP_W      = WIDTH'(lfsr_taps(WIDTH));
   localparam logic [WIDTH-1:0]  SEED_A_RAW = WIDTH'(SEED_A);
   localparam logic [WIDTH-1:0]  SEED_B_RAW = WIDTH'(SEED_B);
   localparam logic [WIDTH-1:0]  SEED_A_EFF = (SEED_A_RAW == '0) ? '1 : SEED_A_RAW;
   localparam logic [WIDTH-1:0]  SEED_B_EFF = (SEED_B_RAW == '0) ? '1 : SEED_B_RAW;

   state_e              state_q, state_d;
   logic                mode_q, mode_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    lfsr_a_q, lfsr_a_d;
   logic [WIDTH-1:0]    lfsr_b_q, lfsr_b_d;
   logic                pass_q, pass_d;
   logic [SESS_W-1:0]   sess_q, sess_d;
   logic [N_SESS-1:0]   vld_q, vld_d;
   logic [SIG_W-1:0]    mem_q [N_SESS];
   logic                mem_we, misr_clr, misr_en, pass_ok;
   logic [SIG_W-1:0]    misr_sig;
`ifdef BIST_DIAG_EN
   logic [SESS_W-1:0]   fail_sess_q, fail_sess_d;
   logic [SIG_W-1:0]    fail_sig_q, fail_sig_d;
   logic                fail_any_q, fail_any_d;
`endif

   bist_misr #(.SIG_W(SIG_W), .IN_W(WIDTH + 1)) u_misr (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (misr_clr),
      .en_i   (misr_en),
      .data_i (dut_sum),
      .sig_o  (misr_sig)
   );

   assign pass_ok = vld_q[sess_q] && (misr_sig == mem_q[sess_q]);

   always_comb begin
      // NOTE: every next-state value defaults to its current value first, so no branch infers a latch.
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      lfsr_a_d = lfsr_a_q;
      lfsr_b_d = lfsr_b_q;
      pass_d   = pass_q;
      sess_d   = sess_q;
      vld_d    = vld_q;
      mem_we   = 1'b0;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
`ifdef BIST_DIAG_EN
      fail_sess_d = fail_sess_q;
      fail_sig_d  = fail_sig_q;
      fail_any_d  = fail_any_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d  = learn;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            misr_clr = 1'b1;
            cnt_d    = '0;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            misr_en  = 1'b1;
            lfsr_a_d = {lfsr_a_q[WIDTH-2:0], ^(lfsr_a_q & TAP_W)};
            lfsr_b_d = {lfsr_b_q[WIDTH-2:0], ^(lfsr_b_q & TAP_W)};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = ST_CMP;
         end
         ST_CMP: begin
            if (mode_q) begin
               mem_we        = 1'b1;
               vld_d[sess_q] = 1'b1;
               pass_d        = 1'b0;
            end else begin
               pass_d = pass_ok;
`ifdef BIST_DIAG_EN
               if (!pass_ok && !fail_any_q) begin
                  fail_sess_d = sess_q;
                  fail_sig_d  = misr_sig;
               end
               fail_any_d = fail_any_q | ~pass_ok;
`endif
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            sess_d  = (sess_q == SESS_LAST) ? '0 : sess_q + SESS_W'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with <= only; the combinational block above uses =.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= 1'b0;
         cnt_q    <= '0;
         lfsr_a_q <= SEED_A_EFF;
         lfsr_b_q <= SEED_B_EFF;
         pass_q   <= 1'b0;
         sess_q   <= '0;
         vld_q    <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         lfsr_a_q <= lfsr_a_d;
         lfsr_b_q <= lfsr_b_d;
         pass_q   <= pass_d;
         sess_q   <= sess_d;
         vld_q    <= vld_d;
      end
   end

   // NOTE: the golden table has no reset; vld_q alone decides whether an entry is meaningful.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[sess_q] <= misr_sig;
   end

`ifdef BIST_DIAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fail_sess_q <= '0;
         fail_sig_q  <= '0;
         fail_any_q  <= 1'b0;
      end else begin
         fail_sess_q <= fail_sess_d;
         fail_sig_q  <= fail_sig_d;
         fail_any_q  <= fail_any_d;
      end
   end

   assign fail_sess = fail_sess_q;
   assign fail_sig  = fail_sig_q;
   assign fail_any  = fail_any_q;
`endif

   assign tpg_a   = lfsr_a_q;
   assign tpg_b   = lfsr_b_q;
   assign tpg_cin = lfsr_a_q[WIDTH-1] ^ lfsr_b_q[0];
   assign busy    = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_CMP);
   assign done    = (state_q == ST_DONE);
   assign pass    = pass_q;
   assign sess    = sess_q;
   assign sig     = misr_sig;

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Directed bench for bist_session_ctrl at default parameters, with a behavioural
// adder, LFSR and MISR model supplying the expected signatures and pass results.
module tb_bist_session_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, learn, stuck;
   logic [6:0] dut_sum;
   logic [5:0] tpg_a, tpg_b;
   logic       tpg_cin, busy, done, pass;
   logic [3:0] sess, sig;
`ifdef BIST_DIAG_EN
   logic [3:0] fail_sess, fail_sig;
   logic       fail_any;
`endif

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [5:0] ma, mb;
   logic [3:0] gold [14];
   bit         gvld [14];
   int         msess;
   bit         ffail;
   int         efs;
   logic [3:0] efsig;

   always #5 clk = ~clk;

   // golden adder with an optional stuck-at-1 on result bit 0
   assign dut_sum = ({1'b0, tpg_a} + {1'b0, tpg_b} + {6'b0, tpg_cin}) | {6'b0, stuck};

   bist_session_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .learn     (learn),
      .dut_sum   (dut_sum),
      .tpg_a     (tpg_a),
      .tpg_b     (tpg_b),
      .tpg_cin   (tpg_cin),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .sess      (sess),
      .sig       (sig)
`ifdef BIST_DIAG_EN
      ,
      .fail_sess (fail_sess),
      .fail_sig  (fail_sig),
      .fail_any  (fail_any)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      ma    = 6'h01;
      mb    = 6'h2A;
      msess = 0;
      ffail = 1'b0;
      efs   = 0;
      efsig = '0;
      for (int i = 0; i < 14; i++) gvld[i] = 1'b0;
   endtask

   task automatic model_session(input bit fault, output logic [3:0] m);
      logic [6:0] s;
      m = '0;
      for (int i = 0; i < 16; i++) begin
         s = 7'(ma) + 7'(mb) + 7'(ma[5] ^ mb[0]);
         if (fault) s[0] = 1'b1;
         m  = {m[2:0], m[3] ^ m[0]} ^ (s[3:0] ^ {1'b0, s[6:4]});
         ma = {ma[4:0], ma[5] ^ ma[0]};
         mb = {mb[4:0], mb[5] ^ mb[0]};
      end
   endtask

   // Starts a session and stops in its done cycle; dcyc = 0 means done never came.
   task automatic run_session(input bit l, input bit poke, output int dcyc, output int bcnt);
      int cyc;
      dcyc  = 0;
      bcnt  = 0;
      start = 1'b1;
      learn = l;
      step();
      cyc = 1;
      while (cyc < 40) begin
         start = poke && (cyc == 5 || cyc == 18);
         learn = poke ? ~l : l;
         if (busy) bcnt++;
         if (done) begin
            dcyc = cyc;
            break;
         end
         step();
         cyc++;
      end
      start = 1'b0;
      learn = 1'b0;
   endtask

   task automatic session(input bit l, input bit poke, input bit fault, input int j);
      logic [3:0] m;
      bit         exp_pass;
      int         dcyc, bcnt;
      model_session(fault, m);
      stuck = fault;
      run_session(l, poke, dcyc, bcnt);
      stuck = 1'b0;
      exp_pass = !l && gvld[msess] && (m == gold[msess]);
      check($sformatf("s%0d_done_cycle", j), dcyc, 19);
      check($sformatf("s%0d_busy_cycles", j), bcnt, 18);
      check($sformatf("s%0d_sig", j), sig, m);
      check($sformatf("s%0d_pass", j), pass, exp_pass);
      check($sformatf("s%0d_sess_during_done", j), sess, msess);
      if (l) begin
         gold[msess] = m;
         gvld[msess] = 1'b1;
      end else if (!exp_pass && !ffail) begin
         ffail = 1'b1;
         efs   = msess;
         efsig = m;
      end
      msess = (msess == 13) ? 0 : msess + 1;
      step();
      check($sformatf("s%0d_done_pulse_end", j), done, 0);
      check($sformatf("s%0d_sess_next", j), sess, msess);
   endtask

   initial begin
      int  c;
      bit  seen;
      rst   = 1'b1;
      start = 1'b0;
      learn = 1'b0;
      stuck = 1'b0;
      model_reset();
      repeat (3) step();
      rst = 1'b0;
      repeat (5) step();

      check("rst_tpg_a", tpg_a, 6'h01);
      check("rst_tpg_b", tpg_b, 6'h2A);
      check("rst_sig", sig, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_sess", sess, 0);

      // learn every table entry
      for (int j = 0; j < 14; j++) session(1'b1, 1'b0, 1'b0, j);
      check("sess_wrap", sess, 0);

      // Check sessions until the LFSR sequences realign with the learned ones:
      // both generators have period 63, so session 126+s reuses session s's patterns.
      // Session 14 gets start pulses in RUN/CMP and a flipped learn; session 131 (s=5) a stuck bit.
      for (int j = 14; j < 140; j++) session(1'b0, j == 14, j == 131, j);

`ifdef BIST_DIAG_EN
      check("diag_fail_any", fail_any, ffail);
      check("diag_fail_sess", fail_sess, efs);
      check("diag_fail_sig", fail_sig, efsig);
`endif

      // start held high: one done every N_PAT+4 cycles
      start = 1'b1;
      c = 0;
      while (!done && c < 40) begin
         step();
         c++;
      end
      check("b2b_first_done", done, 1);
      step();
      c = 1;
      while (!done && c < 40) begin
         step();
         c++;
      end
      check("b2b_period", c, 20);
      start = 1'b0;
      step();
`ifdef BIST_DIAG_EN
      check("diag_fail_any_sticky", fail_any, ffail);
`endif

      // reset, then abort a learn session in its 7th RUN cycle
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      model_reset();
      start = 1'b1;
      learn = 1'b1;
      step();
      start = 1'b0;
      learn = 1'b0;
      step();
      check("run1_tpg_a", tpg_a, 6'h01);
      step();
      check("run2_tpg_a", tpg_a, 6'h03);
      check("run2_tpg_b", tpg_b, 6'h15);
      repeat (5) step();
      rst = 1'b1;
      step();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_tpg_a", tpg_a, 6'h01);
      check("abort_tpg_b", tpg_b, 6'h2A);
      check("abort_sig", sig, 0);
      check("abort_sess", sess, 0);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (done || busy) seen = 1'b1;
      end
      check("abort_quiet", seen, 0);

      // check without any learned entry must fail
      session(1'b0, 1'b0, 1'b0, 200);
      check("unlearned_pass", pass, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
